// File: rtl/dmem_pkg.sv
// Shared types and helpers for the data-memory responder slice.
// Holds the FSM state encoding, word geometry and the byte-lane merge.
package dmem_pkg;

    localparam int WORD_W = 32;
    localparam int BE_W   = 4;

    typedef enum logic [1:0] {
        IDLE,
        WAIT,
        ACCESS,
        RESP
    } state_t;

    // Overlay the enabled byte lanes of wdata onto the old word.
    function automatic logic [WORD_W-1:0] mergeBytes(
        input logic [WORD_W-1:0] oldWord,
        input logic [WORD_W-1:0] wdata,
        input logic [BE_W-1:0]   be
    );
        logic [WORD_W-1:0] r;
        r = oldWord;
        for (int i = 0; i < BE_W; i++) begin
            if (be[i]) r[8*i +: 8] = wdata[8*i +: 8];
        end
        return r;
    endfunction

endpackage

// File: rtl/dmem_array.sv
// Word-addressed RAM: one byte-enabled access port returning the post-write word,
// plus an always-running registered debug read port that sees pre-write contents.
module dmem_array
    import dmem_pkg::*;
#(
    parameter int ADDR_W = 10
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              en,
    input  logic              we,
    input  logic [ADDR_W-1:0] addr,
    input  logic [BE_W-1:0]   be,
    input  logic [WORD_W-1:0] wdata,
    output logic [WORD_W-1:0] rdata,
    input  logic [3:0]        dbgAddr,
    output logic [WORD_W-1:0] dbgData
);

    logic [WORD_W-1:0] mem [2**ADDR_W];
    logic [WORD_W-1:0] newWord;

    always_comb begin
        newWord = mem[addr];
        if (we) newWord = mergeBytes(mem[addr], wdata, be);
    end

    // Contents are deliberately not reset; rst only blocks an in-flight write.
    always_ff @(posedge clk) begin
        if (!rst && en && we) mem[addr] <= newWord;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            rdata   <= '0;
            dbgData <= '0;
        end else begin
            if (en) rdata <= newWord;
            dbgData <= mem[ADDR_W'(dbgAddr)];
        end
    end

endmodule

// File: rtl/dmem_responder.sv
// Multi-cycle load/store responder: latches one request, waits WAIT_CYCLES,
// performs the access, then holds the response until the initiator takes it.
module dmem_responder
    import dmem_pkg::*;
#(
    parameter int ADDR_W      = 10,
    parameter int WAIT_CYCLES = 2,
    parameter int CNT_W       = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic              req_we,
    input  logic [ADDR_W-1:0] req_addr,
    input  logic [3:0]        req_be,
    input  logic [31:0]       req_wdata,
    output logic              rsp_valid,
    input  logic              rsp_ready,
    output logic [31:0]       rsp_rdata,
    input  logic [3:0]        dbg_addr,
    output logic [31:0]       dbg_data,
    output logic [CNT_W-1:0]  rd_count,
    output logic [CNT_W-1:0]  wr_count
);

    localparam int WAIT_LOAD = (WAIT_CYCLES > 0) ? WAIT_CYCLES - 1 : 0;

    state_t            state, nextState;
    logic [3:0]        waitCnt;
    logic              latWe;
    logic [ADDR_W-1:0] latAddr;
    logic [BE_W-1:0]   latBe;
    logic [WORD_W-1:0] latWdata;
    logic              accept, doAccess;

    assign accept   = (state == IDLE) && req_valid;
    assign doAccess = (state == ACCESS);

    always_ff @(posedge clk) begin
        if (rst) state <= IDLE;
        else     state <= nextState;
    end

    always_comb begin
        nextState = state;
        case (state)
            IDLE:    if (req_valid) nextState = (WAIT_CYCLES > 0) ? WAIT : ACCESS;
            WAIT:    if (waitCnt == '0) nextState = ACCESS;
            ACCESS:  nextState = RESP;
            RESP:    if (rsp_ready) nextState = IDLE;
            default: nextState = IDLE;
        endcase
    end

    always_comb begin
        req_ready = (state == IDLE);
        rsp_valid = (state == RESP);
    end

    // Request is captured once at accept; later input activity is ignored.
    always_ff @(posedge clk) begin
        if (accept) begin
            latWe    <= req_we;
            latAddr  <= req_addr;
            latBe    <= req_be;
            latWdata <= req_wdata;
            waitCnt  <= 4'(WAIT_LOAD);
        end else if (state == WAIT && waitCnt != '0) begin
            waitCnt <= waitCnt - 4'd1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            rd_count <= '0;
            wr_count <= '0;
        end else if (doAccess) begin
            if (latWe) begin
                if (wr_count != '1) wr_count <= wr_count + 1'b1;
            end else begin
                if (rd_count != '1) rd_count <= rd_count + 1'b1;
            end
        end
    end

    dmem_array #(.ADDR_W(ADDR_W)) uArray (
        .clk     (clk),
        .rst     (rst),
        .en      (doAccess),
        .we      (latWe),
        .addr    (latAddr),
        .be      (latBe),
        .wdata   (latWdata),
        .rdata   (rsp_rdata),
        .dbgAddr (dbg_addr),
        .dbgData (dbg_data)
    );

endmodule
